router_register: RTL and testbench

- Datapath register stage of the 1x3 packet router, between the input FSM and the three output FIFOs.
- Latches the header byte and forwards header, payload and parity bytes to the FIFO on `dout`.
- Holds one byte while the FIFO is full.
- Computes running XOR parity and flags a parity mismatch on `err`. State decode (`detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`) comes from the router FSM.

---
 rtl/router_pkg.sv | 10 +
 rtl/router_register_if.sv | 27 ++
 rtl/router_parity_chk.sv | 54 +++++
 rtl/router_register.sv | 63 ++++++
 tb/tb_router_register.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared widths and header field layout for the router datapath.
package router_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 1;
    localparam int LEN_LSB = 2;
    localparam int LEN_MSB = 7;
    localparam logic [ADDR_MSB-ADDR_LSB:0] ADDR_INVALID = 2'b11;
    typedef logic [DATA_WIDTH-1:0] byte_t;
endpackage

// File: rtl/router_register_if.sv
// router_register_if: FSM state decode, byte stream and status between router FSM and register stage.
interface router_register_if;
    import router_pkg::*;
    logic  pkt_valid;
    byte_t data_in;
    logic  fifo_full;
    logic  detect_add;
    logic  ld_state;
    logic  laf_state;
    logic  full_state;
    logic  lfd_state;
    logic  rst_int_reg;
    logic  err;
    logic  parity_done;
    logic  low_pkt_valid;
    byte_t dout;
    modport master (
        output pkt_valid, data_in, fifo_full, detect_add, ld_state, laf_state,
               full_state, lfd_state, rst_int_reg,
        input  err, parity_done, low_pkt_valid, dout
    );
    modport slave (
        input  pkt_valid, data_in, fifo_full, detect_add, ld_state, laf_state,
               full_state, lfd_state, rst_int_reg,
        output err, parity_done, low_pkt_valid, dout
    );
endinterface

// File: rtl/router_parity_chk.sv
// router_parity_chk: running XOR parity over header+payload, captured packet parity and mismatch flag.
module router_parity_chk
    import router_pkg::*;
(
    input  logic  clock,
    input  logic  resetn,
    input  logic  detect_add_i,
    input  logic  lfd_state_i,
    input  logic  ld_state_i,
    input  logic  laf_state_i,
    input  logic  full_state_i,
    input  logic  fifo_full_i,
    input  logic  pkt_valid_i,
    input  logic  low_pkt_valid_i,
    input  byte_t header_i,
    input  byte_t data_in_i,
    output logic  parity_done_o,
    output logic  err_o
);
    byte_t int_parity_q, int_parity_d, pkt_parity_q, pkt_parity_d;
    logic  parity_done_q, parity_done_d, err_q, err_d;
    logic  done_set;

    // A parity byte stalled by a full FIFO completes when it is replayed in LOAD_AFTER_FULL.
    assign done_set = (ld_state_i && !fifo_full_i && !pkt_valid_i) ||
                      (laf_state_i && low_pkt_valid_i && !parity_done_q);

    always_comb begin
        int_parity_d  = detect_add_i ? '0 :
                        lfd_state_i ? int_parity_q ^ header_i :
                        (ld_state_i && pkt_valid_i && !full_state_i) ? int_parity_q ^ data_in_i :
                        int_parity_q;
        pkt_parity_d  = (ld_state_i && !pkt_valid_i) ? data_in_i : pkt_parity_q;
        parity_done_d = detect_add_i ? 1'b0 : done_set ? 1'b1 : parity_done_q;
        err_d         = detect_add_i ? 1'b0 : parity_done_q ? (int_parity_q != pkt_parity_q) : err_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            int_parity_q  <= '0;
            pkt_parity_q  <= '0;
            parity_done_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            int_parity_q  <= int_parity_d;
            pkt_parity_q  <= pkt_parity_d;
            parity_done_q <= parity_done_d;
            err_q         <= err_d;
        end
    end

    assign parity_done_o = parity_done_q;
    assign err_o         = err_q;
endmodule

// File: rtl/router_register.sv
// router_register: header latch and byte forwarding to the output FIFO with full-stall holding.
// Define ROUTER_REG_ADDR_CHECK_EN to reject headers carrying the invalid address 2'b11.
module router_register
    import router_pkg::*;
(
    input logic clock,
    input logic resetn,
    router_register_if.slave bus
);
    byte_t header_q, header_d, full_byte_q, full_byte_d, dout_q, dout_d;
    logic  low_pkt_valid_q, low_pkt_valid_d;
    logic  addr_ok;

`ifdef ROUTER_REG_ADDR_CHECK_EN
    assign addr_ok = bus.data_in[ADDR_MSB:ADDR_LSB] != ADDR_INVALID;
`else
    assign addr_ok = 1'b1;
`endif

    always_comb begin
        header_d        = (bus.detect_add && bus.pkt_valid && addr_ok) ? bus.data_in : header_q;
        dout_d          = bus.lfd_state ? header_q :
                          bus.ld_state ? (bus.fifo_full ? dout_q : bus.data_in) :
                          bus.laf_state ? full_byte_q : dout_q;
        full_byte_d     = (!bus.lfd_state && bus.ld_state && bus.fifo_full) ? bus.data_in : full_byte_q;
        low_pkt_valid_d = bus.rst_int_reg ? 1'b0 :
                          (bus.ld_state && !bus.pkt_valid) ? 1'b1 : low_pkt_valid_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_q        <= '0;
            full_byte_q     <= '0;
            dout_q          <= '0;
            low_pkt_valid_q <= 1'b0;
        end else begin
            header_q        <= header_d;
            full_byte_q     <= full_byte_d;
            dout_q          <= dout_d;
            low_pkt_valid_q <= low_pkt_valid_d;
        end
    end

    router_parity_chk u_parity (
        .clock          (clock),
        .resetn         (resetn),
        .detect_add_i   (bus.detect_add),
        .lfd_state_i    (bus.lfd_state),
        .ld_state_i     (bus.ld_state),
        .laf_state_i    (bus.laf_state),
        .full_state_i   (bus.full_state),
        .fifo_full_i    (bus.fifo_full),
        .pkt_valid_i    (bus.pkt_valid),
        .low_pkt_valid_i(low_pkt_valid_q),
        .header_i       (header_q),
        .data_in_i      (bus.data_in),
        .parity_done_o  (bus.parity_done),
        .err_o          (bus.err)
    );

    assign bus.dout          = dout_q;
    assign bus.low_pkt_valid = low_pkt_valid_q;
endmodule

// File: tb/tb_router_register.sv
// tb_router_register: drives FSM state decode directly and checks bytes and flags against a packet-level model.
module tb_router_register;
    import router_pkg::*;

    logic clock = 1'b0;
    logic resetn = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] last_hdr = 8'h00;

    router_register_if bus();

    router_register dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle;
        bus.pkt_valid   = 1'b0;
        bus.data_in     = 8'h00;
        bus.fifo_full   = 1'b0;
        bus.detect_add  = 1'b0;
        bus.ld_state    = 1'b0;
        bus.laf_state   = 1'b0;
        bus.full_state  = 1'b0;
        bus.lfd_state   = 1'b0;
        bus.rst_int_reg = 1'b0;
    endtask

    task automatic test_reset;
        set_idle();
        #2 resetn = 1'b0;
        #1;
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset dout got=%h exp=00", bus.dout); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset err got=%b exp=0", bus.err); end
        checks++; if (bus.parity_done !== 1'b0) begin errors++; $display("FAIL reset parity_done got=%b exp=0", bus.parity_done); end
        checks++; if (bus.low_pkt_valid !== 1'b0) begin errors++; $display("FAIL reset low_pkt_valid got=%b exp=0", bus.low_pkt_valid); end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // fi: position (0..n-1 payload, n parity) that meets a full FIFO; any larger value means never full.
    task automatic send_pkt(input logic [7:0] hdr, input int fi, input logic use_fix,
                            input logic [7:0] fix_par, input logic clr, input string tag);
        logic [7:0] b[$];
        logic [7:0] par, last;
        logic exp_err;
        int n;
        n = int'(hdr[LEN_MSB:LEN_LSB]);
        par = hdr;
        for (int i = 0; i < n; i++) begin
            b.push_back(8'($urandom));
            par ^= b[i];
        end
        if (use_fix && fix_par == par) begin
            b[0] ^= 8'h01;
            par ^= 8'h01;
        end
        exp_err = use_fix;
        b.push_back(use_fix ? fix_par : par);
        set_idle();
        bus.detect_add = 1'b1; bus.pkt_valid = 1'b1; bus.data_in = hdr;
        tick();
        checks++; if (bus.parity_done !== 1'b0) begin errors++; $display("FAIL %s decode parity_done got=%b exp=0", tag, bus.parity_done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL %s decode err got=%b exp=0", tag, bus.err); end
        bus.detect_add = 1'b0; bus.lfd_state = 1'b1; bus.data_in = b[0];
        tick();
        checks++; if (bus.dout !== hdr) begin errors++; $display("FAIL %s header dout got=%h exp=%h", tag, bus.dout, hdr); end
        last_hdr = hdr;
        last = hdr;
        bus.lfd_state = 1'b0;
        for (int j = 0; j <= n; j++) begin
            set_idle();
            bus.ld_state = 1'b1; bus.pkt_valid = (j < n); bus.data_in = b[j]; bus.fifo_full = (j == fi);
            tick();
            if (j == fi) begin
                checks++; if (bus.dout !== last) begin errors++; $display("FAIL %s full hold dout got=%h exp=%h", tag, bus.dout, last); end
                set_idle();
                bus.full_state = 1'b1; bus.fifo_full = 1'b1; bus.pkt_valid = (j < n);
                tick();
                set_idle();
                bus.laf_state = 1'b1; bus.pkt_valid = (j < n);
                tick();
            end
            checks++; if (bus.dout !== b[j]) begin errors++; $display("FAIL %s byte%0d dout got=%h exp=%h", tag, j, bus.dout, b[j]); end
            last = b[j];
        end
        checks++; if (bus.parity_done !== 1'b1) begin errors++; $display("FAIL %s parity_done got=%b exp=1", tag, bus.parity_done); end
        checks++; if (bus.low_pkt_valid !== 1'b1) begin errors++; $display("FAIL %s low_pkt_valid got=%b exp=1", tag, bus.low_pkt_valid); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL %s early err got=%b exp=0", tag, bus.err); end
        set_idle();
        bus.rst_int_reg = clr;
        tick();
        checks++; if (bus.err !== exp_err) begin errors++; $display("FAIL %s err got=%b exp=%b", tag, bus.err, exp_err); end
        checks++; if (bus.low_pkt_valid !== !clr) begin errors++; $display("FAIL %s low_pkt_valid clr got=%b exp=%b", tag, bus.low_pkt_valid, !clr); end
        set_idle();
    endtask

    task automatic test_good_bad;
        send_pkt(8'h16, 99, 1'b0, 8'h00, 1'b1, "good");
        send_pkt(8'h16, 99, 1'b1, 8'h2E, 1'b1, "bad");
        send_pkt(8'h16, 99, 1'b0, 8'h00, 1'b1, "after_bad");
    endtask

    task automatic test_fifo_full;
        send_pkt(8'h16, 2, 1'b0, 8'h00, 1'b1, "full_mid");
        send_pkt(8'h16, 0, 1'b0, 8'h00, 1'b1, "full_first");
        send_pkt(8'h16, 5, 1'b1, 8'h2E, 1'b1, "full_parity");
    endtask

    task automatic test_rst_int_reg;
        set_idle();
        bus.ld_state = 1'b1; bus.data_in = 8'($urandom);
        tick();
        checks++; if (bus.low_pkt_valid !== 1'b1) begin errors++; $display("FAIL rir set got=%b exp=1", bus.low_pkt_valid); end
        set_idle();
        bus.rst_int_reg = 1'b1;
        tick();
        checks++; if (bus.low_pkt_valid !== 1'b0) begin errors++; $display("FAIL rir clear got=%b exp=0", bus.low_pkt_valid); end
        bus.ld_state = 1'b1;
        tick();
        checks++; if (bus.low_pkt_valid !== 1'b0) begin errors++; $display("FAIL rir priority got=%b exp=0", bus.low_pkt_valid); end
        set_idle();
        tick();
    endtask

    task automatic test_addr_check;
        logic [7:0] exp;
`ifdef ROUTER_REG_ADDR_CHECK_EN
        exp = last_hdr;
`else
        exp = 8'h17;
`endif
        set_idle();
        bus.detect_add = 1'b1; bus.pkt_valid = 1'b1; bus.data_in = 8'h17;
        tick();
        set_idle();
        bus.lfd_state = 1'b1;
        tick();
        checks++; if (bus.dout !== exp) begin errors++; $display("FAIL addr3 header got=%h exp=%h", bus.dout, exp); end
        last_hdr = exp;
        set_idle();
        bus.detect_add = 1'b1; bus.data_in = 8'h0A;
        tick();
        set_idle();
        bus.lfd_state = 1'b1;
        tick();
        checks++; if (bus.dout !== last_hdr) begin errors++; $display("FAIL no_valid header got=%h exp=%h", bus.dout, last_hdr); end
        set_idle();
        tick();
    endtask

    task automatic test_reset_mid;
        send_pkt(8'h16, 99, 1'b1, 8'h2E, 1'b0, "pre_reset");
        @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL mid reset dout got=%h exp=00", bus.dout); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL mid reset err got=%b exp=0", bus.err); end
        checks++; if (bus.parity_done !== 1'b0) begin errors++; $display("FAIL mid reset parity_done got=%b exp=0", bus.parity_done); end
        checks++; if (bus.low_pkt_valid !== 1'b0) begin errors++; $display("FAIL mid reset low_pkt_valid got=%b exp=0", bus.low_pkt_valid); end
        tick();
        resetn = 1'b1;
        bus.lfd_state = 1'b1;
        tick();
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL mid reset header got=%h exp=00", bus.dout); end
        last_hdr = 8'h00;
        set_idle();
        send_pkt(8'h16, 99, 1'b0, 8'h00, 1'b1, "post_reset");
    endtask

    task automatic test_random;
        for (int k = 0; k < 8; k++) begin
            int len, addr, fi;
            logic corrupt;
            len = $urandom_range(1, 6);
            addr = $urandom_range(0, 2);
            fi = $urandom_range(0, len + 1);
            corrupt = 1'($urandom_range(0, 1));
            send_pkt({6'(len), 2'(addr)}, fi, corrupt, 8'($urandom), 1'b1, "rnd");
        end
    endtask

    initial begin
        test_reset();
        test_good_bad();
        test_fifo_full();
        test_rst_int_reg();
        test_addr_check();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
